// File: rtl/demux_scheduler.sv
// demux_scheduler: valid/ready byte sequencer for a 1-to-4 demux with addressed or
// round-robin dispatch and a stall timeout. Optional per-channel counters: DEMUX_SCHED_STATS_EN.
module demux_scheduler #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            dest_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  rr_mode_i,
  input  logic [3:0]            ch_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            sel_o,
  output logic                  enable_o,
  output logic                  drop_o
`ifdef DEMUX_SCHED_STATS_EN
  ,
  input  logic [1:0]            stat_sel_i,
  output logic [15:0]           stat_cnt_o,
  input  logic                  stat_clr_i
`endif
);

  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [1:0]            target_q, target_d;
  logic                  target_rr_q, target_rr_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  drop_q, drop_d;
  logic                  enable_q, enable_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  ch_rdy_sel_c;
  logic                  accept_c;
  logic                  deliver_c;
  logic                  timeout_c;
  logic [1:0]            rr_next_c;

  assign ch_rdy_sel_c = ch_ready_i[target_q];
  assign ready_o      = rst_n_i & ((state_q == IDLE) | ch_rdy_sel_c);
  assign accept_c     = valid_i & ready_o;
  assign deliver_c    = (state_q == SEND) & ch_rdy_sel_c;
  assign timeout_c    = TIMEOUT_EN & (state_q == SEND) & ~ch_rdy_sel_c &
                        (stall_cnt_q == CNT_WIDTH'(TO_LAST_INT));
  assign rr_next_c    = target_q + 2'd1;

  // Next-state and datapath loads
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    target_d    = target_q;
    target_rr_d = target_rr_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    drop_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          hold_d      = data_i;
          target_d    = rr_mode_i ? rr_ptr_q : dest_i;
          target_rr_d = rr_mode_i;
          stall_cnt_d = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (deliver_c) begin
          // A back-to-back round-robin byte must see the already-advanced pointer
          if (target_rr_q) rr_ptr_d = rr_next_c;
          stall_cnt_d = '0;
          if (accept_c) begin
            hold_d      = data_i;
            target_d    = rr_mode_i ? rr_ptr_d : dest_i;
            target_rr_d = rr_mode_i;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout_c) begin
          if (target_rr_q) rr_ptr_d = rr_next_c;
          drop_d      = 1'b1;
          stall_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    enable_d = (state_d == SEND);
    data_d   = (state_d == SEND) ? hold_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      target_q    <= '0;
      target_rr_q <= 1'b0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      drop_q      <= 1'b0;
      enable_q    <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      target_q    <= target_d;
      target_rr_q <= target_rr_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      drop_q      <= drop_d;
      enable_q    <= enable_d;
      data_q      <= data_d;
    end
  end

  // sel_o follows target, which only moves on acceptance, so it holds while idle
  assign sel_o    = target_q;
  assign data_o   = data_q;
  assign enable_o = enable_q;
  assign drop_o   = drop_q;

`ifdef DEMUX_SCHED_STATS_EN
  logic [3:0][15:0] stat_q;
  logic [15:0]      stat_rd_q;

  // Saturating per-channel delivery counters; drops are not counted
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || stat_clr_i) begin
      stat_q <= '0;
    end else if (deliver_c && (stat_q[target_q] != 16'hFFFF)) begin
      stat_q[target_q] <= stat_q[target_q] + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) stat_rd_q <= '0;
    else          stat_rd_q <= stat_q[stat_sel_i];
  end

  assign stat_cnt_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// tb_demux_scheduler: vector table plus hand-written timeout/reset sequences, with a
// delivery scoreboard; a second instance runs with the timeout disabled.
module tb_demux_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [1:0] dest  = 2'd0;
  logic       valid = 1'b0;
  logic       rr    = 1'b0;
  logic [3:0] ch    = 4'hF;

  logic       ready, en, drop;
  logic [7:0] dout;
  logic [1:0] sel;
  logic       ready0, en0, drop0;
  logic [7:0] dout0;
  logic [1:0] sel0;

`ifdef DEMUX_SCHED_STATS_EN
  logic [1:0]  stat_sel = 2'd0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cnt, stat_cnt0;
`endif

  demux_scheduler #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .dest_i(dest), .valid_i(valid),
    .ready_o(ready), .rr_mode_i(rr), .ch_ready_i(ch), .data_o(dout), .sel_o(sel),
    .enable_o(en), .drop_o(drop)
`ifdef DEMUX_SCHED_STATS_EN
    , .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt), .stat_clr_i(stat_clr)
`endif
  );

  demux_scheduler #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(0), .CNT_WIDTH(5)) u_dut_t0 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .dest_i(dest), .valid_i(valid),
    .ready_o(ready0), .rr_mode_i(rr), .ch_ready_i(ch), .data_o(dout0), .sel_o(sel0),
    .enable_o(en0), .drop_o(drop0)
`ifdef DEMUX_SCHED_STATS_EN
    , .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt0), .stat_clr_i(stat_clr)
`endif
  );

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [1:0] dest;
    logic       rr;
    logic [3:0] ch;
    logic       chk;
    logic       e_ready;
    logic       e_en;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic       e_drop;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  localparam int NV = 25;
  vec_t       vecs [NV];
  exp_t       sbq [$];
  int         exp_cnt [4];
  logic [1:0] model_rr;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [1:0] ds, input logic m, input logic [3:0] c,
                              input logic k, input logic erdy, input logic een,
                              input logic [1:0] esel, input logic [7:0] edat,
                              input logic edrp);
    vec_t x;
    x.rst_n = r;  x.valid = v;  x.data = d;  x.dest = ds; x.rr = m; x.ch = c;
    x.chk = k;    x.e_ready = erdy; x.e_en = een; x.e_sel = esel;
    x.e_data = edat; x.e_drop = edrp;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, then score what the last rising edge produced
  task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                       input logic [1:0] ds, input logic m, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    rst_n = r; valid = v; data = d; dest = ds; rr = m; ch = c;
    #1;
    if (drop === 1'b1) begin
      if (sbq.size() == 0) check("sb_drop_underflow", 32'd1, 32'd0);
      else e = sbq.pop_front();
    end
    if (en === 1'b1 && ch[sel] === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_deliver_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_sel", 32'(sel), 32'(e.sel));
        check("sb_data", 32'(dout), 32'(e.data));
        exp_cnt[sel] = exp_cnt[sel] + 1;
      end
    end
    if (!r) begin
      sbq.delete();
      model_rr = 2'd0;
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end else if (v && ready === 1'b1) begin
      e.sel  = m ? model_rr : ds;
      e.data = d;
      if (m) model_rr = model_rr + 2'd1;
      sbq.push_back(e);
    end
  endtask

`ifdef DEMUX_SCHED_STATS_EN
  task automatic check_stats(input string tag);
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("%s_stat%0d", tag, i), 32'(stat_cnt), 32'(exp_cnt[i]));
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rise, dropat, drops, drops0, late_drops;
    model_rr = 2'd0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

    //            rst v  data   dst rr ch     chk rdy en sel dat   drp
    vecs[0]  = mk(0, 0, 8'h00, 0, 0, 4'hF,  0, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 0, 4'hF,  1, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0, 4'hF,  1, 0, 0, 0, 8'h00, 0);
    vecs[3]  = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 0, 0, 8'h00, 0);
    vecs[4]  = mk(1, 1, 8'h11, 0, 0, 4'hF,  1, 1, 0, 0, 8'h00, 0);
    vecs[5]  = mk(1, 1, 8'h22, 1, 0, 4'hF,  1, 1, 1, 0, 8'h11, 0);
    vecs[6]  = mk(1, 1, 8'h33, 2, 0, 4'hF,  1, 1, 1, 1, 8'h22, 0);
    vecs[7]  = mk(1, 1, 8'h44, 3, 0, 4'hF,  1, 1, 1, 2, 8'h33, 0);
    vecs[8]  = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 1, 3, 8'h44, 0);
    vecs[9]  = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 0, 3, 8'h00, 0);
    vecs[10] = mk(1, 1, 8'hA0, 3, 1, 4'hF,  1, 1, 0, 3, 8'h00, 0);
    vecs[11] = mk(1, 1, 8'hA1, 3, 1, 4'hF,  1, 1, 1, 0, 8'hA0, 0);
    vecs[12] = mk(1, 1, 8'hA2, 3, 1, 4'hF,  1, 1, 1, 1, 8'hA1, 0);
    vecs[13] = mk(1, 1, 8'hA3, 3, 1, 4'hF,  1, 1, 1, 2, 8'hA2, 0);
    vecs[14] = mk(1, 1, 8'hA4, 3, 1, 4'hF,  1, 1, 1, 3, 8'hA3, 0);
    vecs[15] = mk(1, 0, 8'h00, 0, 1, 4'hF,  1, 1, 1, 0, 8'hA4, 0);
    vecs[16] = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 0, 0, 8'h00, 0);
    vecs[17] = mk(1, 1, 8'h5A, 2, 0, 4'hB,  1, 1, 0, 0, 8'h00, 0);
    for (int i = 18; i <= 22; i++)
      vecs[i] = mk(1, 0, 8'h00, 0, 0, 4'hB, 1, 0, 1, 2, 8'h5A, 0);
    vecs[23] = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 1, 2, 8'h5A, 0);
    vecs[24] = mk(1, 0, 8'h00, 0, 0, 4'hF,  1, 1, 0, 2, 8'h00, 0);

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].data, vecs[i].dest, vecs[i].rr, vecs[i].ch);
      if (vecs[i].chk) begin
        check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].e_ready));
        check($sformatf("v%0d_enable", i), 32'(en), 32'(vecs[i].e_en));
        check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
        check($sformatf("v%0d_data", i), 32'(dout), 32'(vecs[i].e_data));
        check($sformatf("v%0d_drop", i), 32'(drop), 32'(vecs[i].e_drop));
      end
    end
    check("table_sb_empty", 32'(sbq.size()), 32'd0);
`ifdef DEMUX_SCHED_STATS_EN
    check_stats("table");
`endif

    // Timeout: round-robin pointer sits at 1, channel 1 never ready
    cycle(1, 1, 8'hFF, 2'd0, 1, 4'b1101);
    check("to_accept_ready", 32'(ready), 32'd1);
    rise = -1; dropat = -1; drops = 0; drops0 = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(1, 0, 8'h00, 2'd0, 1, 4'b1101);
      if (en === 1'b1 && rise < 0) rise = k;
      if (drop === 1'b1) begin
        drops++;
        if (dropat < 0) dropat = k;
      end
      if (drop0 !== 1'b0) drops0++;
    end
    check("to_enable_rise", 32'(rise), 32'd1);
    check("to_drop_delay", 32'(dropat - rise), 32'd16);
    check("to_drop_once", 32'(drops), 32'd1);
    check("to_idle_ready", 32'(ready), 32'd1);
    check("to_idle_enable", 32'(en), 32'd0);
    check("t0_never_drops", 32'(drops0), 32'd0);
    check("t0_still_enable", 32'(en0), 32'd1);
    check("t0_still_sel", 32'(sel0), 32'd1);
    check("t0_still_data", 32'(dout0), 32'hFF);
    check("t0_not_ready", 32'(ready0), 32'd0);

    cycle(1, 1, 8'hC3, 2'd0, 1, 4'hF);
    cycle(1, 0, 8'h00, 2'd0, 1, 4'hF);
    check("to_next_rr_sel", 32'(sel), 32'd2);
    check("to_next_rr_data", 32'(dout), 32'hC3);
    check("to_next_rr_en", 32'(en), 32'd1);

    // Reset in the middle of a stall
    cycle(1, 1, 8'h77, 2'd3, 0, 4'b0111);
    for (int k = 0; k < 3; k++) cycle(1, 0, 8'h00, 2'd0, 0, 4'b0111);
    check("mr_stall_sel", 32'(sel), 32'd3);
    check("mr_stall_ready", 32'(ready), 32'd0);
    cycle(0, 0, 8'h00, 2'd0, 0, 4'b0111);
    check("mr_rst_ready", 32'(ready), 32'd0);
    cycle(1, 0, 8'h00, 2'd0, 0, 4'b0111);
    check("mr_enable", 32'(en), 32'd0);
    check("mr_sel", 32'(sel), 32'd0);
    check("mr_data", 32'(dout), 32'h00);
    check("mr_drop", 32'(drop), 32'd0);
    check("mr_ready", 32'(ready), 32'd1);
    late_drops = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 0, 8'h00, 2'd0, 0, 4'b0111);
      if (drop !== 1'b0) late_drops++;
    end
    check("mr_no_drop", 32'(late_drops), 32'd0);
    cycle(1, 1, 8'hE1, 2'd2, 1, 4'hF);
    cycle(1, 0, 8'h00, 2'd0, 0, 4'hF);
    check("mr_rr_restart_sel", 32'(sel), 32'd0);
    check("mr_rr_restart_data", 32'(dout), 32'hE1);
    check("t0_rr_restart_sel", 32'(sel0), 32'd0);
    check("t0_rr_restart_en", 32'(en0), 32'd1);
    cycle(1, 0, 8'h00, 2'd0, 0, 4'hF);
    check("end_sb_empty", 32'(sbq.size()), 32'd0);

`ifdef DEMUX_SCHED_STATS_EN
    check_stats("final");
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    check_stats("clr");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
